// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: brings the PLL out of reset, waits for lock, then steps
// individual output phases through PSSEL/PSDIR/PSPULSE while tracking each phase.
module pll_phase_stepper #(
    parameter int NUM_CH       = 2,
    parameter int PHASE_STEPS  = 400,
    parameter int PHASE_W      = 9,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_W      = 4,
    parameter int GAP          = 16,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pll_lock,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_ch,
    input  logic                      req_dir,
    input  logic [PHASE_W-1:0]        req_steps,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic                      locked,
    output logic                      lock_lost,
    input  logic                      clear_lost,
    output logic [NUM_CH*PHASE_W-1:0] phase,
    output logic                      pll_reset,
    output logic [2:0]                ps_sel,
    output logic                      ps_dir,
    output logic                      ps_pulse
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + RST_CYCLES + GAP + PULSE_W + SETUP_CYC + 1);

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, IDLE, SETUP, PULSE_HI, PULSE_LO, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           sync_q, sync_d;
    logic [PHASE_W-1:0]   rem_q, rem_d;
    logic [PHASE_W-1:0]   phase_q [NUM_CH];
    logic [PHASE_W-1:0]   phase_d [NUM_CH];
    logic                 pll_reset_q, pll_reset_d, ps_dir_q, ps_dir_d, ps_pulse_q, ps_pulse_d;
    logic [2:0]           ps_sel_q, ps_sel_d;
    logic                 req_ready_q, req_ready_d, busy_q, busy_d, locked_q, locked_d;
    logic                 done_q, done_d, err_q, err_d, lock_lost_q, lock_lost_d;
    logic                 clr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        sync_d      = {sync_q[0], pll_lock};
        rem_d       = rem_q;
        phase_d     = phase_q;
        pll_reset_d = pll_reset_q;
        ps_sel_d    = ps_sel_q;
        ps_dir_d    = ps_dir_q;
        ps_pulse_d  = ps_pulse_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        lock_lost_d = clear_lost ? 1'b0 : lock_lost_q;
        clr         = 1'b0;
        case (state_q)
            PLL_RST: if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                state_d     = WAIT_LOCK;
                cnt_d       = '0;
                pll_reset_d = 1'b0;
            end
            WAIT_LOCK: if (sync_q[1]) begin
                state_d     = IDLE;
                locked_d    = 1'b1;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                state_d     = PLL_RST;
                cnt_d       = '0;
                pll_reset_d = 1'b1;
                clr         = 1'b1;
            end
            IDLE: if (req_valid) begin
                req_ready_d = 1'b0;
                busy_d      = 1'b1;
                cnt_d       = '0;
                rem_d       = req_steps;
                if (int'(req_ch) >= NUM_CH || req_steps == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = int'(req_ch) >= NUM_CH;
                end else begin
                    state_d  = SETUP;
                    ps_sel_d = req_ch;
                    ps_dir_d = req_dir;
                end
            end
            SETUP: if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                state_d    = PULSE_HI;
                cnt_d      = '0;
                ps_pulse_d = 1'b1;
            end
            PULSE_HI: if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                state_d    = PULSE_LO;
                cnt_d      = '0;
                ps_pulse_d = 1'b0;
                rem_d      = rem_q - PHASE_W'(1);
                for (int i = 0; i < NUM_CH; i++)
                    if (ps_sel_q == 3'(i))
                        phase_d[i] = ps_dir_q
                            ? (phase_q[i] == '0 ? PHASE_W'(PHASE_STEPS - 1) : phase_q[i] - PHASE_W'(1))
                            : (phase_q[i] == PHASE_W'(PHASE_STEPS - 1) ? '0 : phase_q[i] + PHASE_W'(1));
            end
            PULSE_LO: if (cnt_q == CNT_W'(GAP - 1)) begin
                state_d    = rem_q == '0 ? DONE : PULSE_HI;
                cnt_d      = '0;
                ps_pulse_d = rem_q != '0;
                done_d     = rem_q == '0;
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = PLL_RST;
        endcase
        // Lock loss overrides whatever the FSM chose; an in-flight or just-offered request is aborted.
        if (!sync_q[1] && state_q inside {IDLE, SETUP, PULSE_HI, PULSE_LO}) begin
            state_d     = PLL_RST;
            cnt_d       = '0;
            pll_reset_d = 1'b1;
            ps_pulse_d  = 1'b0;
            req_ready_d = 1'b0;
            busy_d      = 1'b1;
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
            done_d      = state_q != IDLE || req_valid;
            err_d       = state_q != IDLE || req_valid;
            clr         = 1'b1;
        end
        if (clr)
            for (int i = 0; i < NUM_CH; i++) phase_d[i] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            sync_q      <= '0;
            rem_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
            pll_reset_q <= 1'b1;
            ps_sel_q    <= '0;
            ps_dir_q    <= 1'b0;
            ps_pulse_q  <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            rem_q       <= rem_d;
            phase_q     <= phase_d;
            pll_reset_q <= pll_reset_d;
            ps_sel_q    <= ps_sel_d;
            ps_dir_q    <= ps_dir_d;
            ps_pulse_q  <= ps_pulse_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb
        for (int i = 0; i < NUM_CH; i++) phase[i*PHASE_W +: PHASE_W] = phase_q[i];

    assign pll_reset = pll_reset_q;
    assign ps_sel    = ps_sel_q;
    assign ps_dir    = ps_dir_q;
    assign ps_pulse  = ps_pulse_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign done      = done_q;
    assign err       = err_q;
    assign lock_lost = lock_lost_q;
endmodule
